pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline: drives the enable and flush inputs of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits with a fixed priority. It also keeps saturating stall/flush performance counters and a sticky memory-timeout error. Sits beside the datapath in the CPU top level; purely control, no datapath values pass through it.

---
 rtl/pipeline_ctrl_pkg.sv | 14 +
 rtl/pipeline_ctrl_if.sv | 56 +++++
 rtl/pipeline_ctrl_sat_counter.sv | 24 ++
 rtl/pipeline_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
// Shared types for the pipeline stall/flush sequencer: the sequencer FSM
// state encoding and the register-specifier width used by the hazard compare.
package pipeline_ctrl_pkg;

    // Register specifier width (x0..x31)
    localparam int REG_W = 5;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if
// Bundle between the datapath and the stall/flush sequencer.
//   Datapath -> sequencer : hazard info (idex_*, ifid_*), branch_taken_i,
//                           exmem_memreq_i, dmem_ready_i
//   Sequencer -> datapath : dmem_req_o, per-stage enables and flushes,
//                           performance counters, mem_err_o, state_o (debug)
// Handshake: dmem_req_o mirrors exmem_memreq_i; an access completes in the
// cycle dmem_ready_i is high while the request is high. Ready without a
// request carries no meaning and is ignored.
interface pipeline_ctrl_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    logic             idex_memread_i;
    logic [REG_W-1:0] idex_rd_i;
    logic [REG_W-1:0] ifid_rs1_i;
    logic [REG_W-1:0] ifid_rs2_i;
    logic             branch_taken_i;
    logic             exmem_memreq_i;
    logic             dmem_ready_i;

    logic             dmem_req_o;
    logic             pc_en_o;
    logic             ifid_en_o;
    logic             idex_en_o;
    logic             exmem_en_o;
    logic             memwb_en_o;
    logic             ifid_flush_o;
    logic             idex_flush_o;
    logic             memwb_flush_o;
    logic [CNT_W-1:0] stall_cycles_o;
    logic [CNT_W-1:0] flush_count_o;
    logic             mem_err_o;
    state_t           state_o;

    // Sequencer side
    modport master (
        input  idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i,
        input  branch_taken_i, exmem_memreq_i, dmem_ready_i,
        output dmem_req_o, pc_en_o, ifid_en_o, idex_en_o, exmem_en_o,
        output memwb_en_o, ifid_flush_o, idex_flush_o, memwb_flush_o,
        output stall_cycles_o, flush_count_o, mem_err_o, state_o
    );

    // Datapath side
    modport slave (
        output idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i,
        output branch_taken_i, exmem_memreq_i, dmem_ready_i,
        input  dmem_req_o, pc_en_o, ifid_en_o, idex_en_o, exmem_en_o,
        input  memwb_en_o, ifid_flush_o, idex_flush_o, memwb_flush_o,
        input  stall_cycles_o, flush_count_o, mem_err_o, state_o
    );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock
//   rst   : synchronous active-high clear
//   inc   : add one this cycle
//   count : current value
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Stall/flush sequencer for the 5-stage pipeline. Resolves, highest first:
// data-memory wait, load-use hazard, taken branch. Also keeps saturating
// stall/flush counters and a sticky memory-timeout error.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : pipeline_ctrl_if.master (hazard inputs, enables/flushes,
//                  dmem request, counters, error, debug state)
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input logic             clk_i,
    input logic             rst_i,
    pipeline_ctrl_if.master bus
);

    localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_t            r_state;
    state_t            w_next_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_err;

    logic w_mem_stall;
    logic w_load_use;
    logic w_pc_en;
    logic w_ifid_en;
    logic w_idex_en;
    logic w_exmem_en;
    logic w_memwb_en;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_memwb_flush;
    logic w_dmem_req;

    assign w_mem_stall = bus.exmem_memreq_i & ~bus.dmem_ready_i;

    // x0 is never written, so a load to x0 cannot create a dependency
    assign w_load_use = bus.idex_memread_i && (bus.idex_rd_i != '0) &&
                        ((bus.idex_rd_i == bus.ifid_rs1_i) ||
                         (bus.idex_rd_i == bus.ifid_rs2_i));

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: a zero-wait access never leaves RUN because the stall
    // term is already false in the request cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RUN:      if (w_mem_stall)  w_next_state = MEM_WAIT;
            MEM_WAIT: if (!w_mem_stall) w_next_state = RUN;
            default:  w_next_state = RUN;
        endcase
    end

    // Outputs: fixed-priority mux. Lower-priority events are simply not
    // acted on; the frozen front stages present them again later.
    always_comb begin
        w_pc_en       = 1'b1;
        w_ifid_en     = 1'b1;
        w_idex_en     = 1'b1;
        w_exmem_en    = 1'b1;
        w_memwb_en    = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_memwb_flush = 1'b0;
        w_dmem_req    = bus.exmem_memreq_i;
        if (rst_i) begin
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_memwb_flush = 1'b1;
            w_dmem_req    = 1'b0;
        end else if (w_mem_stall) begin
            // Freeze the front; bubble into MEM_WB so WB never writes twice
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_en     = 1'b0;
            w_exmem_en    = 1'b0;
            w_memwb_flush = 1'b1;
        end else if (w_load_use) begin
            // Branch operands are stale here; it is re-evaluated next cycle
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
        end else if (bus.branch_taken_i) begin
            w_ifid_flush = 1'b1;
        end
    end

    // Wait counter tracks stalled cycles of the current access (the entry
    // cycle included), so the error fires after MEM_TIMEOUT stalled cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            if (w_next_state == RUN) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != WAIT_MAX) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_mem_stall && (r_wait_cnt >= WAIT_MAX - 1'b1)) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (~w_pc_en & ~rst_i),
        .count (bus.stall_cycles_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (w_ifid_flush & ~rst_i),
        .count (bus.flush_count_o)
    );

    assign bus.dmem_req_o    = w_dmem_req;
    assign bus.pc_en_o       = w_pc_en;
    assign bus.ifid_en_o     = w_ifid_en;
    assign bus.idex_en_o     = w_idex_en;
    assign bus.exmem_en_o    = w_exmem_en;
    assign bus.memwb_en_o    = w_memwb_en;
    assign bus.ifid_flush_o  = w_ifid_flush;
    assign bus.idex_flush_o  = w_idex_flush;
    assign bus.memwb_flush_o = w_memwb_flush;
    assign bus.mem_err_o     = r_mem_err;
    assign bus.state_o       = r_state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
// Table-driven vectors for the priority mux plus hand-written sequences for
// memory waits, timeout, counter saturation and reset during a wait.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int CNT_W = 4;
    localparam int TMO   = 4;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, memwb_fl, dmem_req}
    localparam logic [8:0] O_NORM     = 9'b11111_000_0;
    localparam logic [8:0] O_NORM_REQ = 9'b11111_000_1;
    localparam logic [8:0] O_MEM      = 9'b00001_001_1;
    localparam logic [8:0] O_LU       = 9'b00111_010_0;
    localparam logic [8:0] O_LU_REQ   = 9'b00111_010_1;
    localparam logic [8:0] O_BR       = 9'b11111_100_0;
    localparam logic [8:0] O_BR_REQ   = 9'b11111_100_1;
    localparam logic [8:0] O_RST      = 9'b11111_111_0;

    typedef struct {
        string      name;
        logic       memread;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       br;
        logic       memreq;
        logic       ready;
        logic [8:0] exp;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // Clock / watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard
    logic [8:0] exp_q[$];
    string      name_q[$];
    vec_t       vec_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    function automatic logic [8:0] outs();
        return {bus.pc_en_o, bus.ifid_en_o, bus.idex_en_o, bus.exmem_en_o,
                bus.memwb_en_o, bus.ifid_flush_o, bus.idex_flush_o,
                bus.memwb_flush_o, bus.dmem_req_o};
    endfunction

    task automatic check_val(input string name, input logic [31:0] got,
                             input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Driver tasks: called at posedge+1, inputs held for one cycle
    task automatic drive(input logic memread, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic br, input logic memreq, input logic ready);
        bus.idex_memread_i = memread;
        bus.idex_rd_i      = rd;
        bus.ifid_rs1_i     = rs1;
        bus.ifid_rs2_i     = rs2;
        bus.branch_taken_i = br;
        bus.exmem_memreq_i = memreq;
        bus.dmem_ready_i   = ready;
    endtask

    task automatic drive_idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Push expectation, compare combinational outputs at negedge, then
    // advance past the next active edge.
    task automatic cycle(input string name, input logic [8:0] exp);
        logic [8:0] want;
        logic [8:0] got;
        string      nm;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk_i);
        got  = outs();
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: outputs got %b want %b", nm, got, want);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        drive_idle();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic add_vec(input string name, input logic memread,
                           input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic br,
                           input logic memreq, input logic ready,
                           input logic [8:0] exp);
        vec_t v;
        v.name = name; v.memread = memread; v.rd = rd; v.rs1 = rs1;
        v.rs2 = rs2; v.br = br; v.memreq = memreq; v.ready = ready;
        v.exp = exp;
        vec_q.push_back(v);
    endtask

    initial begin
        //       name           mrd rd     rs1    rs2    br    req   rdy   expected
        add_vec("idle",         1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_NORM);
        add_vec("lu_rs2",       1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, O_LU);
        add_vec("lu_x0",        1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_NORM);
        add_vec("lu_rs1",       1'b1, 5'd5, 5'd5, 5'd2, 1'b0, 1'b0, 1'b0, O_LU);
        add_vec("no_load",      1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, O_NORM);
        add_vec("branch",       1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, O_BR);
        add_vec("lu_and_br",    1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, O_LU);
        add_vec("mem_zero_wt",  1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, O_NORM_REQ);
        add_vec("mem_wait1",    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, O_MEM);
        add_vec("mem_wait_all", 1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, O_MEM);
        add_vec("mem_rel_lu",   1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, O_LU_REQ);
        add_vec("ready_noreq",  1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, O_NORM);
        add_vec("load_nodep",   1'b1, 5'd7, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, O_NORM);
        add_vec("br_with_req",  1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, O_BR_REQ);

        // Reset behaviour
        drive_idle();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        cycle("rst_outputs", O_RST);
        check_val("rst_state", 32'(bus.state_o), 32'(RUN));
        check_val("rst_stall_cnt", 32'(bus.stall_cycles_o), 0);
        check_val("rst_flush_cnt", 32'(bus.flush_count_o), 0);
        check_val("rst_mem_err", 32'(bus.mem_err_o), 0);
        rst_i = 1'b0;

        // Vector table
        foreach (vec_q[i]) begin
            drive(vec_q[i].memread, vec_q[i].rd, vec_q[i].rs1, vec_q[i].rs2,
                  vec_q[i].br, vec_q[i].memreq, vec_q[i].ready);
            cycle(vec_q[i].name, vec_q[i].exp);
        end
        check_val("tbl_stall_cnt", 32'(bus.stall_cycles_o), 6);
        check_val("tbl_flush_cnt", 32'(bus.flush_count_o), 2);
        check_val("tbl_mem_err", 32'(bus.mem_err_o), 0);

        // Load-use: one stall cycle; rd=x0 gives none
        do_reset();
        drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
        cycle("seq_lu", O_LU);
        check_val("seq_lu_stall", 32'(bus.stall_cycles_o), 1);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        cycle("seq_lu_x0", O_NORM);
        check_val("seq_lu_x0_stall", 32'(bus.stall_cycles_o), 1);

        // Taken branch alone, then together with load-use
        do_reset();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        cycle("seq_br", O_BR);
        check_val("seq_br_flush", 32'(bus.flush_count_o), 1);
        do_reset();
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
        cycle("seq_lu_br", O_LU);
        check_val("seq_lu_br_flush", 32'(bus.flush_count_o), 0);
        check_val("seq_lu_br_stall", 32'(bus.stall_cycles_o), 1);

        // Three-cycle memory wait
        do_reset();
        check_val("mw_state0", 32'(bus.state_o), 32'(RUN));
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            cycle($sformatf("mw_stall%0d", k), O_MEM);
            check_val($sformatf("mw_state%0d", k), 32'(bus.state_o), 32'(MEM_WAIT));
            check_val($sformatf("mw_stall_cnt%0d", k), 32'(bus.stall_cycles_o), 32'(k));
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        cycle("mw_release", O_NORM_REQ);
        check_val("mw_state_rel", 32'(bus.state_o), 32'(RUN));
        check_val("mw_stall_final", 32'(bus.stall_cycles_o), 3);
        check_val("mw_err", 32'(bus.mem_err_o), 0);

        // Memory wait masking load-use and branch
        do_reset();
        for (int k = 1; k <= 2; k++) begin
            drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
            cycle($sformatf("mwh_stall%0d", k), O_MEM);
        end
        check_val("mwh_flush_mask", 32'(bus.flush_count_o), 0);
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1);
        cycle("mwh_release_lu", O_LU_REQ);
        drive(1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
        cycle("mwh_branch", O_BR);
        check_val("mwh_stall_cnt", 32'(bus.stall_cycles_o), 3);
        check_val("mwh_flush_cnt", 32'(bus.flush_count_o), 1);

        // Timeout after the 4th wait cycle, sticky until reset
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            cycle($sformatf("tmo_stall%0d", k), O_MEM);
            check_val($sformatf("tmo_err%0d", k), 32'(bus.mem_err_o), (k >= TMO) ? 1 : 0);
            check_val($sformatf("tmo_state%0d", k), 32'(bus.state_o), 32'(MEM_WAIT));
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        cycle("tmo_release", O_NORM_REQ);
        check_val("tmo_err_after_rdy", 32'(bus.mem_err_o), 1);
        check_val("tmo_state_rel", 32'(bus.state_o), 32'(RUN));
        check_val("tmo_stall_cnt", 32'(bus.stall_cycles_o), 10);
        drive_idle();
        cycle("tmo_idle", O_NORM);
        check_val("tmo_err_idle", 32'(bus.mem_err_o), 1);
        do_reset();
        check_val("tmo_err_cleared", 32'(bus.mem_err_o), 0);

        // Stall counter saturation at 15
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            drive(1'b1, 5'd6, 5'd6, 5'd1, 1'b0, 1'b0, 1'b0);
            cycle($sformatf("sat_lu%0d", k), O_LU);
            check_val($sformatf("sat_cnt%0d", k), 32'(bus.stall_cycles_o), (k > 15) ? 15 : k);
        end

        // Reset asserted mid-wait abandons the access
        do_reset();
        for (int k = 1; k <= 2; k++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
            cycle($sformatf("rmw_stall%0d", k), O_MEM);
        end
        check_val("rmw_state_wait", 32'(bus.state_o), 32'(MEM_WAIT));
        check_val("rmw_stall_pre", 32'(bus.stall_cycles_o), 2);
        rst_i = 1'b1;
        cycle("rmw_rst1", O_RST);
        check_val("rmw_state_run", 32'(bus.state_o), 32'(RUN));
        check_val("rmw_stall_zero", 32'(bus.stall_cycles_o), 0);
        check_val("rmw_flush_zero", 32'(bus.flush_count_o), 0);
        check_val("rmw_err_zero", 32'(bus.mem_err_o), 0);
        cycle("rmw_rst2", O_RST);
        check_val("rmw_stall_hold", 32'(bus.stall_cycles_o), 0);
        check_val("rmw_flush_hold", 32'(bus.flush_count_o), 0);
        rst_i = 1'b0;
        drive_idle();
        cycle("rmw_after", O_NORM);
        check_val("rmw_state_after", 32'(bus.state_o), 32'(RUN));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
